// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: emulator state encoding, microsecond timing constants
// and the frame checksum / duration-reached helpers.
package dht11_pkg;

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        MEDE_START  = 4'd1,
        ESPERA_RESP = 4'd2,
        RESP_BAIXO  = 4'd3,
        RESP_ALTO   = 4'd4,
        BIT_BAIXO   = 4'd5,
        BIT_ALTO    = 4'd6,
        FIM_BAIXO   = 4'd7
    } estado_t;

    localparam int          T_START_PADRAO_US = 18000;
    localparam logic [15:0] T_ESPERA_US       = 16'd30;
    localparam logic [15:0] T_RESP_US         = 16'd80;
    localparam logic [15:0] T_BIT_BAIXO_US    = 16'd50;
    localparam logic [15:0] T_BIT0_US         = 16'd26;
    localparam logic [15:0] T_BIT1_US         = 16'd70;
    localparam logic [15:0] T_FIM_US          = 16'd50;

    function automatic logic [7:0] soma_verificacao(input logic [7:0] a, input logic [7:0] b,
                                                    input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

    // True on the last cycle of an interval of 'alvo' microseconds, so the
    // state leaves exactly alvo*CICLOS_US cycles after the timer was cleared.
    function automatic logic atingiu(input logic [15:0] us, input logic tick, input logic [15:0] alvo);
        return (us >= alvo) || (tick && (us == alvo - 16'd1));
    endfunction

endpackage

// File: rtl/dht11_emulador_if.sv
// Data/status bundle between the reading source and the DHT11 emulator.
// Optional injeta_erro exists only with DHT11_EMU_ERRO_CHECKSUM_EN defined.
interface dht11_emulador_if;
    logic [7:0] umidade_int;
    logic [7:0] umidade_dec;
    logic [7:0] temperatura_int;
    logic [7:0] temperatura_dec;
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    logic       injeta_erro;
`endif
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    modport master (output umidade_int, umidade_dec, temperatura_int, temperatura_dec, injeta_erro,
                    input  ocupado, pronto, db_estado);
    modport slave  (input  umidade_int, umidade_dec, temperatura_int, temperatura_dec, injeta_erro,
                    output ocupado, pronto, db_estado);
`else
    modport master (output umidade_int, umidade_dec, temperatura_int, temperatura_dec,
                    input  ocupado, pronto, db_estado);
    modport slave  (input  umidade_int, umidade_dec, temperatura_int, temperatura_dec,
                    output ocupado, pronto, db_estado);
`endif
endinterface

// File: rtl/dht11_emulador_temporizador.sv
// Microsecond timer: CICLOS_US prescaler feeding a saturating 16-bit us counter,
// both cleared together by limpa_i.
module dht11_temporizador #(
    parameter int CICLOS_US = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        limpa_i,
    output logic [15:0] us_o,
    output logic        tick_o
);
    logic [15:0] pres_q, pres_d;
    logic [15:0] us_q, us_d;

    assign tick_o = (pres_q == 16'(CICLOS_US - 1));
    assign us_o   = us_q;

    // Next prescaler / microsecond count
    always_comb begin
        pres_d = pres_q;
        us_d   = us_q;
        if (limpa_i) begin
            pres_d = 16'd0;
            us_d   = 16'd0;
        end else if (tick_o) begin
            pres_d = 16'd0;
            if (us_q != 16'hFFFF) begin
                us_d = us_q + 16'd1;
            end else begin
                us_d = us_q;
            end
        end else begin
            pres_d = pres_q + 16'd1;
        end
    end

    // Timer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pres_q <= 16'd0;
            us_q   <= 16'd0;
        end else begin
            pres_q <= pres_d;
            us_q   <= us_d;
        end
    end
endmodule

// File: rtl/dht11_emulador.sv
// DHT11 sensor emulator on an open-drain single-wire bus.
// Define DHT11_EMU_ERRO_CHECKSUM_EN to add injeta_erro (corrupts checksum LSB).
module dht11_emulador
    import dht11_pkg::*;
#(
    parameter int CICLOS_US  = 50,
    parameter int T_START_US = T_START_PADRAO_US
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire               dht_bus,
    dht11_emulador_if.slave   dados
);
    estado_t     estado_q, estado_d;
    logic [39:0] quadro_q, quadro_d;
    logic [5:0]  bit_q, bit_d;
    logic        sinc1_q, sinc2_q;
    logic        baixo_q, ocupado_q, pronto_q;
    logic        limpa_s, tick_s, fim_s;
    logic [15:0] us_s, duracao_s;
    logic [7:0]  soma_s;

    dht11_temporizador #(.CICLOS_US(CICLOS_US)) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .limpa_i (limpa_s),
        .us_o    (us_s),
        .tick_o  (tick_s)
    );

    assign dht_bus         = baixo_q ? 1'b0 : 1'bz;
    assign dados.ocupado   = ocupado_q;
    assign dados.pronto    = pronto_q;
    assign dados.db_estado = estado_q;

`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    assign soma_s = soma_verificacao(dados.umidade_int, dados.umidade_dec, dados.temperatura_int,
                                     dados.temperatura_dec) ^ {7'd0, dados.injeta_erro};
`else
    assign soma_s = soma_verificacao(dados.umidade_int, dados.umidade_dec, dados.temperatura_int,
                                     dados.temperatura_dec);
`endif

    // Length of the current state; bit-high length follows the MSB being sent
    always_comb begin
        case (estado_q)
            ESPERA_RESP: duracao_s = T_ESPERA_US;
            RESP_BAIXO:  duracao_s = T_RESP_US;
            RESP_ALTO:   duracao_s = T_RESP_US;
            BIT_BAIXO:   duracao_s = T_BIT_BAIXO_US;
            BIT_ALTO:    duracao_s = quadro_q[39] ? T_BIT1_US : T_BIT0_US;
            FIM_BAIXO:   duracao_s = T_FIM_US;
            default:     duracao_s = 16'(T_START_US);
        endcase
    end

    assign fim_s = atingiu(us_s, tick_s, duracao_s);

    // Next-state logic; every transition clears the microsecond timer
    always_comb begin
        estado_d = estado_q;
        quadro_d = quadro_q;
        bit_d    = bit_q;
        limpa_s  = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (!sinc2_q) begin
                    estado_d = MEDE_START;
                    limpa_s  = 1'b1;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            MEDE_START: begin
                if (sinc2_q) begin
                    limpa_s = 1'b1;
                    if (fim_s) begin
                        estado_d = ESPERA_RESP;
                        quadro_d = {dados.umidade_int, dados.umidade_dec, dados.temperatura_int,
                                    dados.temperatura_dec, soma_s};
                        bit_d    = 6'd0;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end else begin
                    estado_d = MEDE_START;
                end
            end
            ESPERA_RESP, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, FIM_BAIXO: begin
                if (fim_s) begin
                    limpa_s = 1'b1;
                    case (estado_q)
                        ESPERA_RESP: estado_d = RESP_BAIXO;
                        RESP_BAIXO:  estado_d = RESP_ALTO;
                        RESP_ALTO:   estado_d = BIT_BAIXO;
                        BIT_BAIXO:   estado_d = BIT_ALTO;
                        default:     estado_d = OCIOSO;
                    endcase
                end else begin
                    estado_d = estado_q;
                end
            end
            BIT_ALTO: begin
                if (fim_s) begin
                    limpa_s  = 1'b1;
                    quadro_d = {quadro_q[38:0], 1'b0};
                    if (bit_q == 6'd39) begin
                        estado_d = FIM_BAIXO;
                    end else begin
                        estado_d = BIT_BAIXO;
                        bit_d    = bit_q + 6'd1;
                    end
                end else begin
                    estado_d = BIT_ALTO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // State, frame and output registers; bus drive follows the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            quadro_q  <= 40'd0;
            bit_q     <= 6'd0;
            sinc1_q   <= 1'b1;
            sinc2_q   <= 1'b1;
            baixo_q   <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            quadro_q  <= quadro_d;
            bit_q     <= bit_d;
            sinc1_q   <= dht_bus;
            sinc2_q   <= sinc1_q;
            baixo_q   <= (estado_d inside {RESP_BAIXO, BIT_BAIXO, FIM_BAIXO});
            ocupado_q <= !(estado_d inside {OCIOSO, MEDE_START});
            pronto_q  <= (estado_q == FIM_BAIXO) && (estado_d == OCIOSO);
        end
    end
endmodule

// File: tb/tb_dht11_emulador.sv
// Bench for dht11_emulador: a host with pull-up issues start pulses and decodes
// the returned frame by measuring bus pulse widths against a byte-level model.
`timescale 1ns/1ps
module tb_dht11_emulador;
    localparam int C   = 2;
    localparam int TS  = 180;
    localparam int LIM = 120 * C + 20;

    logic clock = 1'b0;
    logic reset;
    logic host_baixo;
    logic silencio;
    wire  dht_bus;
    int   n_cmp = 0;
    int   n_falha = 0;
    int   n_pronto = 0;
    logic pronto_ant = 1'b0;
    logic inj_atual = 1'b0;

    dht11_emulador_if dif();

    pullup (dht_bus);
    assign dht_bus = host_baixo ? 1'b0 : 1'bz;

    dht11_emulador #(.CICLOS_US(C), .T_START_US(TS)) dut (
        .clock   (clock),
        .reset   (reset),
        .dht_bus (dht_bus),
        .dados   (dif)
    );

    always #10 clock = ~clock;

    function automatic logic [39:0] modelo(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d, input logic inj);
        int s;
        logic [7:0] ck;
        s  = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        ck = 8'(s);
        if (inj) ck = ck ^ 8'h01;
        return {a, b, c, d, ck};
    endfunction

    task automatic confere(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_falha++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
        end
    endtask

    task automatic confere_faixa(input string nome, input int atual, input int mn, input int mx);
        n_cmp++;
        if (atual < mn || atual > mx) begin
            n_falha++;
            $display("FAIL %s: got %0d cycles expected %0d..%0d", nome, atual, mn, mx);
        end
    endtask

    task automatic poe_dados(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        dif.umidade_int     = a;
        dif.umidade_dec     = b;
        dif.temperatura_int = c;
        dif.temperatura_dec = d;
    endtask

    // Host start pulse: bus held low for us_baixo microseconds, then released
    task automatic inicia(input int us_baixo);
        @(negedge clock);
        silencio   = 1'b1;
        host_baixo = 1'b1;
        repeat (us_baixo * C) @(posedge clock);
        @(negedge clock);
        host_baixo = 1'b0;
        silencio   = 1'b0;
    endtask

    // Width in cycles of the next bus run at level 'nivel' (bounded waits)
    task automatic segmento(input logic nivel, output int dur, output bit ok, input int sonda);
        int n = 0;
        ok  = 1'b1;
        dur = 0;
        while (dht_bus !== nivel && n < LIM) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= LIM) begin
            ok = 1'b0;
            n_cmp++; n_falha++;
            $display("FAIL segmento: bus never reached %0b within %0d cycles", nivel, LIM);
            return;
        end
        while (dht_bus === nivel && dur < LIM) begin
            dur++;
            if (dur == sonda) confere("ocupado_espera", {63'd0, dif.ocupado}, 64'd1);
            @(posedge clock); #1;
        end
        if (dur >= LIM) begin
            ok = 1'b0;
            n_cmp++; n_falha++;
            $display("FAIL segmento: bus stuck at %0b for %0d cycles", nivel, LIM);
        end
    endtask

    task automatic recebe(input logic [39:0] esp, input string nome, input int parar, output logic [39:0] lido);
        int d;
        bit ok;
        int base;
        lido = 40'd0;
        base = n_pronto;
        @(posedge clock); #1;
        segmento(1'b1, d, ok, 10);
        if (!ok) return;
        confere_faixa({nome, "_espera"}, d, 30 * C, 30 * C + 4);
        segmento(1'b0, d, ok, -1);
        if (!ok) return;
        confere_faixa({nome, "_resp_baixo"}, d, 80 * C - 1, 80 * C + 1);
        segmento(1'b1, d, ok, -1);
        if (!ok) return;
        confere_faixa({nome, "_resp_alto"}, d, 80 * C - 1, 80 * C + 1);
        for (int i = 0; i < 40; i++) begin
            if (i == parar) begin
                repeat (5) @(posedge clock);
                @(negedge clock);
                reset = 1'b1;
                @(posedge clock); #1;
                confere({nome, "_reset_bus"}, {63'd0, dht_bus}, 64'd1);
                confere({nome, "_reset_ocupado"}, {63'd0, dif.ocupado}, 64'd0);
                confere({nome, "_reset_pronto"}, {63'd0, dif.pronto}, 64'd0);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            segmento(1'b0, d, ok, -1);
            if (!ok) return;
            confere_faixa($sformatf("%s_bit%0d_baixo", nome, i), d, 50 * C - 1, 50 * C + 1);
            segmento(1'b1, d, ok, -1);
            if (!ok) return;
            confere_faixa($sformatf("%s_bit%0d_alto", nome, i), d,
                          (esp[39 - i] ? 70 : 26) * C - 1, (esp[39 - i] ? 70 : 26) * C + 1);
            lido[39 - i] = (d > 48 * C);
        end
        segmento(1'b0, d, ok, -1);
        if (!ok) return;
        confere_faixa({nome, "_fim_baixo"}, d, 50 * C - 1, 50 * C + 1);
        confere({nome, "_liberado"}, {63'd0, dht_bus}, 64'd1);
        repeat (4) begin @(posedge clock); #1; end
        confere({nome, "_pronto_pulsos"}, 64'(n_pronto - base), 64'd1);
        confere({nome, "_ocupado_fim"}, {63'd0, dif.ocupado}, 64'd0);
        confere({nome, "_quadro"}, {24'd0, lido}, {24'd0, esp});
    endtask

    // Per-cycle checks: pronto single-cycle, DUT only pulls low while busy, idle windows quiet
    always @(posedge clock) begin
        #1;
        if (reset === 1'b0) begin
            if (dif.pronto === 1'b1) begin
                n_pronto++;
                confere("pronto_um_ciclo", {63'd0, pronto_ant}, 64'd0);
            end
            if (dht_bus === 1'b0 && !host_baixo)
                confere("ocupado_bus_baixo", {63'd0, dif.ocupado}, 64'd1);
            if (silencio) begin
                confere("silencio_ocupado", {63'd0, dif.ocupado}, 64'd0);
                confere("silencio_bus", {63'd0, dht_bus}, host_baixo ? 64'd0 : 64'd1);
            end
        end
        pronto_ant = dif.pronto;
    end

    initial begin
        logic [39:0] lido;
        logic [39:0] esp;
        logic [7:0]  r [4];
        int          base;
        reset      = 1'b1;
        host_baixo = 1'b0;
        silencio   = 1'b0;
        poe_dados(8'h00, 8'h00, 8'h00, 8'h00);
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
        dif.injeta_erro = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        confere("reset_bus", {63'd0, dht_bus}, 64'd1);
        confere("reset_ocupado", {63'd0, dif.ocupado}, 64'd0);
        confere("reset_pronto", {63'd0, dif.pronto}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        poe_dados(8'h37, 8'h00, 8'h18, 8'h03);
        inicia(TS);
        recebe(modelo(8'h37, 8'h00, 8'h18, 8'h03, 1'b0), "q1", 40, lido);
        confere("q1_literal", {24'd0, lido}, {24'd0, 40'h37_00_18_03_52});

        base = n_pronto;
        inicia(100);
        silencio = 1'b1;
        repeat (200 * C) @(posedge clock);
        #1;
        silencio = 1'b0;
        confere("curto_sem_pronto", 64'(n_pronto - base), 64'd0);

        poe_dados(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        inicia(TS);
        recebe(modelo(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0), "ff", 40, lido);
        confere("ff_checksum", {56'd0, lido[7:0]}, 64'hFC);

        poe_dados(8'h37, 8'h00, 8'h18, 8'h03);
        inicia(TS);
        fork
            recebe(modelo(8'h37, 8'h00, 8'h18, 8'h03, 1'b0), "meio", 40, lido);
            begin
                repeat (3000) @(negedge clock);
                poe_dados(8'h00, 8'h00, 8'h00, 8'h00);
            end
        join
        confere("meio_literal", {24'd0, lido}, {24'd0, 40'h37_00_18_03_52});

        poe_dados(8'h12, 8'h34, 8'h56, 8'h78);
        inicia(TS);
        recebe(modelo(8'h12, 8'h34, 8'h56, 8'h78, 1'b0), "rst", 20, lido);
        inicia(TS);
        recebe(modelo(8'h12, 8'h34, 8'h56, 8'h78, 1'b0), "pos_rst", 40, lido);
        confere("pos_rst_literal", {24'd0, lido}, {24'd0, 40'h12_34_56_78_14});

        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) r[j] = 8'($urandom_range(0, 255));
            poe_dados(r[0], r[1], r[2], r[3]);
            esp = modelo(r[0], r[1], r[2], r[3], inj_atual);
            inicia(TS);
            fork
                recebe(esp, $sformatf("rand%0d", k), 40, lido);
                begin
                    repeat (2000) @(negedge clock);
                    poe_dados(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
            join
        end

`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
        poe_dados(8'h37, 8'h00, 8'h18, 8'h03);
        dif.injeta_erro = 1'b1;
        inj_atual       = 1'b1;
        inicia(TS);
        recebe(modelo(8'h37, 8'h00, 8'h18, 8'h03, inj_atual), "erro", 40, lido);
        confere("erro_checksum", {56'd0, lido[7:0]}, 64'h53);
        dif.injeta_erro = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_falha);
        $finish;
    end
endmodule
